// File: rtl/clk_lock_monitor.sv
// PLL lock supervisor: synchronises, qualifies and tracks NUM_CH lock inputs and derives a downstream reset.
// Optional blinking heartbeat LED is built when LOCK_MON_HEARTBEAT_EN is defined.

module clk_lock_chan #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lock_async,
    input  logic             clear_sticky,
    output logic             lock_ok,
    output logic             lost_sticky,
    output logic [CNT_W-1:0] loss_count
);
    localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {UNLOCKED, QUALIFY, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_nxt;
    logic [QW-1:0]          q, q_nxt;
    logic                   loss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], lock_async};
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNLOCKED;
            q     <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
        end
    end

    // Only a drop out of LOCKED counts as a loss; aborting a qualification does not.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        loss      = 1'b0;
        case (state)
            UNLOCKED: if (s) begin
                state_nxt = QUALIFY;
                q_nxt     = '0;
            end
            QUALIFY: begin
                if (!s)              state_nxt = UNLOCKED;
                else if (q == Q_LAST) state_nxt = LOCKED;
                else                 q_nxt = q + 1'b1;
            end
            LOCKED: if (!s) begin
                state_nxt = UNLOCKED;
                loss      = 1'b1;
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    assign lock_ok = (state == LOCKED);

    // A loss coinciding with a clear survives as the first event of the new epoch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_sticky <= 1'b0;
            loss_count  <= '0;
        end else if (clear_sticky) begin
            lost_sticky <= loss;
            loss_count  <= CNT_W'(loss);
        end else if (loss) begin
            lost_sticky <= 1'b1;
            if (loss_count != '1) loss_count <= loss_count + 1'b1;
        end
    end
endmodule

module clk_lock_monitor #(
    parameter int NUM_CH        = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8,
    parameter int HEARTBEAT_DIV = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       lock_in,
    input  logic                    clear_sticky,
    output logic [NUM_CH-1:0]       lock_ok,
    output logic                    all_locked,
    output logic                    rst_out,
    output logic [NUM_CH-1:0]       lost_sticky,
    output logic [NUM_CH*CNT_W-1:0] loss_count,
    output logic                    heartbeat_led
);
    if (NUM_CH < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1 || CNT_W < 1 || HEARTBEAT_DIV < 3) begin : g_bad_param
        $error("clk_lock_monitor: parameter out of range");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_lock_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .lock_async  (lock_in[i]),
            .clear_sticky(clear_sticky),
            .lock_ok     (lock_ok[i]),
            .lost_sticky (lost_sticky[i]),
            .loss_count  (loss_count[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_locked <= 1'b0;
            rst_out    <= 1'b1;
        end else begin
            all_locked <= &lock_ok;
            rst_out    <= ~all_locked;
        end
    end

`ifdef LOCK_MON_HEARTBEAT_EN
    logic [HEARTBEAT_DIV-1:0] hb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hb <= '0;
        else       hb <= hb + 1'b1;
    end

    // Fast blink flags a clock fault, slow blink means everything is locked.
    assign heartbeat_led = all_locked ? hb[HEARTBEAT_DIV-1] : hb[HEARTBEAT_DIV-3];
`else
    assign heartbeat_led = all_locked;
`endif
endmodule

// File: tb/tb_clk_lock_monitor.sv
// Scoreboard bench for clk_lock_monitor: a run-length reference model predicts every output per edge.
// Directed phases (qualify, glitch, loss, saturation, clear/loss collision) then randomized lock traffic with resets.

module tb_clk_lock_monitor;
    localparam int NUM_CH = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int CNT_W  = 4;
    localparam int HB_DIV = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       lock_in = '0;
    logic                    clear_sticky = 1'b0;
    logic [NUM_CH-1:0]       lock_ok;
    logic                    all_locked;
    logic                    rst_out;
    logic [NUM_CH-1:0]       lost_sticky;
    logic [NUM_CH*CNT_W-1:0] loss_count;
    logic                    heartbeat_led;

    clk_lock_monitor #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
        .CNT_W(CNT_W), .HEARTBEAT_DIV(HB_DIV)
    ) dut (
        .clk(clk), .reset(reset), .lock_in(lock_in), .clear_sticky(clear_sticky),
        .lock_ok(lock_ok), .all_locked(all_locked), .rst_out(rst_out),
        .lost_sticky(lost_sticky), .loss_count(loss_count), .heartbeat_led(heartbeat_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]       ok;
        logic                    all;
        logic                    rst;
        logic [NUM_CH-1:0]       sticky;
        logic [NUM_CH*CNT_W-1:0] cnt;
        logic                    led;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: a channel is locked after edge n iff lock_in was sampled high at
    // every edge from n-SYNC-STABLE to n-SYNC since the last reset.
    bit m_ok[NUM_CH];
    bit m_sticky[NUM_CH];
    int m_cnt[NUM_CH];
    bit m_all = 1'b0;
    bit m_rst = 1'b1;
    int m_hb  = 0;
    bit hist[NUM_CH][$];

    function automatic bit window_high(input int ch);
        int sz = hist[ch].size();
        if (sz < SYNC + STABLE + 1) return 1'b0;
        for (int k = 0; k <= STABLE; k++)
            if (!hist[ch][sz-1-SYNC-k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit loss_if(input int ch, input bit v);
        bit r;
        if (!m_ok[ch]) return 1'b0;
        hist[ch].push_back(v);
        r = window_high(ch);
        void'(hist[ch].pop_back());
        return !r;
    endfunction

    task automatic model_edge(input bit r, input bit [NUM_CH-1:0] li, input bit clr);
        exp_t e;
        bit   all_new;
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_ok[c] = 0; m_sticky[c] = 0; m_cnt[c] = 0; hist[c].delete();
            end
            m_all = 0; m_rst = 1; m_hb = 0;
        end else begin
            all_new = 1'b1;
            for (int c = 0; c < NUM_CH; c++) all_new &= m_ok[c];
            m_rst = !m_all;
            m_all = all_new;
            for (int c = 0; c < NUM_CH; c++) begin
                bit nok, loss;
                hist[c].push_back(li[c]);
                if (hist[c].size() > 32) void'(hist[c].pop_front());
                nok  = window_high(c);
                loss = m_ok[c] && !nok;
                if (clr) begin
                    m_sticky[c] = loss;
                    m_cnt[c]    = loss ? 1 : 0;
                end else if (loss) begin
                    m_sticky[c] = 1;
                    if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
                end
                m_ok[c] = nok;
            end
            m_hb = (m_hb + 1) % (1 << HB_DIV);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            e.ok[c]     = m_ok[c];
            e.sticky[c] = m_sticky[c];
            e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        e.all = m_all;
        e.rst = m_rst;
`ifdef LOCK_MON_HEARTBEAT_EN
        e.led = m_all ? m_hb[HB_DIV-1] : m_hb[HB_DIV-3];
`else
        e.led = m_all;
`endif
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit [NUM_CH-1:0] li, input bit clr);
        @(posedge clk);
        #2;
        reset = r; lock_in = li; clear_sticky = clr;
        model_edge(r, li, clr);
        if (r) begin
            #1;
            chk("async_rst_lock_ok", 32'(lock_ok), 32'd0);
            chk("async_rst_rst_out", 32'(rst_out), 32'd1);
            chk("async_rst_all_locked", 32'(all_locked), 32'd0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("lock_ok", 32'(lock_ok), 32'(e.ok));
                chk("all_locked", 32'(all_locked), 32'(e.all));
                chk("rst_out", 32'(rst_out), 32'(e.rst));
                chk("lost_sticky", 32'(lost_sticky), 32'(e.sticky));
                chk("loss_count", 32'(loss_count), 32'(e.cnt));
                chk("heartbeat_led", 32'(heartbeat_led), 32'(e.led));
            end
        end
    end

    initial begin : stim
        int rem[NUM_CH];
        bit [NUM_CH-1:0] cur;
        int rst_left;
        bit hit;
        repeat (3)  step(1, 2'b00, 0);
        repeat (20) step(0, 2'b00, 0);
        repeat (20) step(0, 2'b11, 0);
        // ch0 drops, then glitches shorter than the window, then re-qualifies
        repeat (6)  step(0, 2'b10, 0);
        repeat (5)  step(0, 2'b11, 0);
        repeat (5)  step(0, 2'b10, 0);
        repeat (15) step(0, 2'b11, 0);
        // ch1 short drop is a real loss
        repeat (3)  step(0, 2'b01, 0);
        repeat (15) step(0, 2'b11, 0);
        // drive ch0 through enough losses to saturate its counter
        for (int n = 0; n < 2 * CNT_MAX; n++) begin
            repeat (10) step(0, 2'b11, 0);
            repeat (2)  step(0, 2'b10, 0);
        end
        // land clear_sticky exactly on a loss edge
        for (int n = 0; n < 4; n++) begin
            repeat (10) step(0, 2'b11, 0);
            hit = 0;
            for (int k = 0; k < 3; k++) begin
                bit clr = !hit && loss_if(0, 1'b0);
                hit |= clr;
                step(0, 2'b10, clr);
            end
        end
        step(0, 2'b11, 1);
        // randomized run-length lock traffic with sporadic resets and clears
        cur = '0;
        rem[0] = 0; rem[1] = 0;
        rst_left = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = cur[c] ? $urandom_range(1, 30) : $urandom_range(1, 5);
                end
                rem[c]--;
            end
            if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
            if (rst_left > 0) begin
                rst_left--;
                step(1, cur, 0);
            end else begin
                step(0, cur, $urandom_range(0, 63) == 0);
            end
        end
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
